// File: rtl/lzc32_sync.sv
// Purpose: registered zero counter that reports where the first set bit sits.
//          It counts from the LSB (trailing, MODE=0) or from the MSB (leading, MODE=1).
//          It also flags an all-zero input.
// Latency: 1 cycle. in_i is sampled at a rising edge, and cnt_o/empty_o hold the result until the next edge.
// Backpressure: none. The block takes a new sample every cycle and has no handshake.
// Ports:
//   clk_i    clock; all state changes on the rising edge
//   rst_i    synchronous reset, active high (cnt_o <= 0, empty_o <= 1)
//   in_i     WIDTH-bit vector to scan
//   cnt_o    CNT_W-bit zero count, registered (0 when empty)
//   empty_o  1 when the sampled in_i was all zeros, registered
module lzc32_sync #(
   parameter int unsigned WIDTH = 32,
   parameter logic        MODE  = 1'b0,
   localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [WIDTH-1:0] in_i,
   output logic [CNT_W-1:0] cnt_o,
   output logic             empty_o
);

   // The tree operates on a power-of-two vector. The zero padding always sits above
   // the scanned MSB. Padding cannot change the count of a non-zero input, and it
   // cannot make a non-zero input look empty.
   localparam int unsigned PAD_W = 1 << CNT_W;

   logic [PAD_W-1:0] scan_vec;

   // Heap-ordered tree. Node 1 is the root, and the leaves occupy PAD_W..2*PAD_W-1.
   // Each node stores whether its subtree holds a set bit, and the offset of the
   // lowest set bit inside that subtree.
   logic             node_vld [1:2*PAD_W-1];
   logic [CNT_W-1:0] node_cnt [1:2*PAD_W-1];

   logic [CNT_W-1:0] cnt_d,   cnt_q;
   logic             empty_d, empty_q;

   always_comb begin
      // Leading-zero mode bit-reverses the input. After that, both modes reduce to
      // counting trailing zeros, and the padding lands below the original LSB.
      scan_vec = '0;
      for (int i = 0; i < int'(WIDTH); i++) begin
         scan_vec[i] = MODE ? in_i[int'(WIDTH) - 1 - i] : in_i[i];
      end

      for (int k = 1; k < 2 * int'(PAD_W); k++) begin
         node_vld[k] = 1'b0;
         node_cnt[k] = '0;
      end

      for (int i = 0; i < int'(PAD_W); i++) begin
         node_vld[int'(PAD_W) + i] = scan_vec[i];
      end

      // Level l combines pairs of subtrees that each hold 2**l leaves. If the lower
      // half contains a set bit, the lower half wins. Otherwise the upper half wins,
      // and its offset moves up by 2**l, which sets bit l of the count.
      for (int l = 0; l < int'(CNT_W); l++) begin
         for (int j = 0; j < (int'(PAD_W) >> (l + 1)); j++) begin
            node_vld[(int'(PAD_W) >> (l + 1)) + j] =
               node_vld[2 * ((int'(PAD_W) >> (l + 1)) + j)] |
               node_vld[2 * ((int'(PAD_W) >> (l + 1)) + j) + 1];
            node_cnt[(int'(PAD_W) >> (l + 1)) + j] =
               node_vld[2 * ((int'(PAD_W) >> (l + 1)) + j)]
                  ? node_cnt[2 * ((int'(PAD_W) >> (l + 1)) + j)]
                  : (node_cnt[2 * ((int'(PAD_W) >> (l + 1)) + j) + 1] | (CNT_W'(1) << l));
         end
      end

      // An empty root would otherwise hold an all-ones count, so force the result to 0.
      empty_d = ~node_vld[1];
      cnt_d   = node_vld[1] ? node_cnt[1] : '0;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q   <= '0;
         empty_q <= 1'b1;
      end else begin
         cnt_q   <= cnt_d;
         empty_q <= empty_d;
      end
   end

   assign cnt_o   = cnt_q;
   assign empty_o = empty_q;

endmodule

// File: tb/tb_lzc32_sync.sv
// Purpose: directed and random checks of lzc32_sync in several width/mode configurations.
// Latency: each check samples 1 ns after the edge that registers the driven input.
// Backpressure: none; inputs are driven on the falling edge, one vector per cycle.
module tb_lzc32_sync;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [31:0] in32 = '0;
   logic [55:0] in56 = '0;
   logic [6:0]  in7  = '0;
   logic [0:0]  in1  = '0;

   logic [4:0] c32z, c32l;
   logic [5:0] c56z, c56l;
   logic [2:0] c7z, c7l;
   logic [0:0] c1z, c1l;
   logic e32z, e32l, e56z, e56l, e7z, e7l, e1z, e1l;

   int errors = 0;
   int checks = 0;

   lzc32_sync #(.WIDTH(32), .MODE(1'b0)) u32z (.clk_i(clk), .rst_i(rst), .in_i(in32), .cnt_o(c32z), .empty_o(e32z));
   lzc32_sync #(.WIDTH(32), .MODE(1'b1)) u32l (.clk_i(clk), .rst_i(rst), .in_i(in32), .cnt_o(c32l), .empty_o(e32l));
   lzc32_sync #(.WIDTH(56), .MODE(1'b0)) u56z (.clk_i(clk), .rst_i(rst), .in_i(in56), .cnt_o(c56z), .empty_o(e56z));
   lzc32_sync #(.WIDTH(56), .MODE(1'b1)) u56l (.clk_i(clk), .rst_i(rst), .in_i(in56), .cnt_o(c56l), .empty_o(e56l));
   lzc32_sync #(.WIDTH(7),  .MODE(1'b0)) u7z  (.clk_i(clk), .rst_i(rst), .in_i(in7),  .cnt_o(c7z),  .empty_o(e7z));
   lzc32_sync #(.WIDTH(7),  .MODE(1'b1)) u7l  (.clk_i(clk), .rst_i(rst), .in_i(in7),  .cnt_o(c7l),  .empty_o(e7l));
   lzc32_sync #(.WIDTH(1),  .MODE(1'b0)) u1z  (.clk_i(clk), .rst_i(rst), .in_i(in1),  .cnt_o(c1z),  .empty_o(e1z));
   lzc32_sync #(.WIDTH(1),  .MODE(1'b1)) u1l  (.clk_i(clk), .rst_i(rst), .in_i(in1),  .cnt_o(c1l),  .empty_o(e1l));

   // Behavioural reference: a straightforward scan from the counted end.
   function automatic int ref_cnt(input logic [63:0] v, input int w, input bit mode);
      int  r     = 0;
      bit  found = 1'b0;
      for (int i = 0; i < w; i++) begin
         if (!found && v[mode ? (w - 1 - i) : i]) begin
            r     = i;
            found = 1'b1;
         end
      end
      return r;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst  = 1'b1;
      in32 = 32'h0000_0008;
      in56 = 56'h1;
      in7  = 7'h7F;
      in1  = 1'b1;
      step();
      step();
      checks++; if (c32z !== 5'd0 || e32z !== 1'b1) begin errors++; $display("FAIL reset32z cnt=%0d empty=%b want 0/1", c32z, e32z); end
      checks++; if (c32l !== 5'd0 || e32l !== 1'b1) begin errors++; $display("FAIL reset32l cnt=%0d empty=%b want 0/1", c32l, e32l); end
      checks++; if (c56z !== 6'd0 || e56z !== 1'b1) begin errors++; $display("FAIL reset56z cnt=%0d empty=%b want 0/1", c56z, e56z); end
      checks++; if (c1l !== 1'b0 || e1l !== 1'b1) begin errors++; $display("FAIL reset1l cnt=%0d empty=%b want 0/1", c1l, e1l); end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_basic();
      @(negedge clk);
      in32 = 32'h0000_0008;
      step();
      checks++; if (c32z !== 5'd3  || e32z !== 1'b0) begin errors++; $display("FAIL tz32_8 cnt=%0d empty=%b want 3/0", c32z, e32z); end
      checks++; if (c32l !== 5'd28 || e32l !== 1'b0) begin errors++; $display("FAIL lz32_8 cnt=%0d empty=%b want 28/0", c32l, e32l); end
      @(negedge clk);
      in32 = 32'hFFFF_FFFF;
      step();
      checks++; if (c32z !== 5'd0 || e32z !== 1'b0) begin errors++; $display("FAIL tz32_ones cnt=%0d empty=%b want 0/0", c32z, e32z); end
      checks++; if (c32l !== 5'd0 || e32l !== 1'b0) begin errors++; $display("FAIL lz32_ones cnt=%0d empty=%b want 0/0", c32l, e32l); end
      @(negedge clk);
      in32 = 32'h8000_0000;
      step();
      checks++; if (c32z !== 5'd31 || e32z !== 1'b0) begin errors++; $display("FAIL tz32_msb cnt=%0d empty=%b want 31/0", c32z, e32z); end
      checks++; if (c32l !== 5'd0  || e32l !== 1'b0) begin errors++; $display("FAIL lz32_msb cnt=%0d empty=%b want 0/0", c32l, e32l); end
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      in32 = 32'h0;
      step();
      checks++; if (c32z !== 5'd0 || e32z !== 1'b1) begin errors++; $display("FAIL tz32_zero cnt=%0d empty=%b want 0/1", c32z, e32z); end
      checks++; if (c32l !== 5'd0 || e32l !== 1'b1) begin errors++; $display("FAIL lz32_zero cnt=%0d empty=%b want 0/1", c32l, e32l); end
      @(negedge clk);
      in32 = 32'h0000_0001;
      step();
      checks++; if (c32z !== 5'd0  || e32z !== 1'b0) begin errors++; $display("FAIL tz32_b2b cnt=%0d empty=%b want 0/0", c32z, e32z); end
      checks++; if (c32l !== 5'd31 || e32l !== 1'b0) begin errors++; $display("FAIL lz32_b2b cnt=%0d empty=%b want 31/0", c32l, e32l); end
   endtask

   task automatic test_odd_widths();
      @(negedge clk);
      in56 = ~56'h0000_0000_0000_07;
      in7  = 7'b000_0100;
      in1  = 1'b1;
      step();
      checks++; if (c56z !== 6'd3 || e56z !== 1'b0) begin errors++; $display("FAIL tz56_napot cnt=%0d empty=%b want 3/0", c56z, e56z); end
      checks++; if (c56l !== 6'd0 || e56l !== 1'b0) begin errors++; $display("FAIL lz56_napot cnt=%0d empty=%b want 0/0", c56l, e56l); end
      checks++; if (c7z !== 3'd2 || e7z !== 1'b0) begin errors++; $display("FAIL tz7 cnt=%0d empty=%b want 2/0", c7z, e7z); end
      checks++; if (c7l !== 3'd4 || e7l !== 1'b0) begin errors++; $display("FAIL lz7 cnt=%0d empty=%b want 4/0", c7l, e7l); end
      checks++; if (c1z !== 1'b0 || e1z !== 1'b0) begin errors++; $display("FAIL w1_one cnt=%0d empty=%b want 0/0", c1z, e1z); end
      @(negedge clk);
      in56 = 56'h80_0000_0000_0000;
      in7  = 7'b000_0001;
      in1  = 1'b0;
      step();
      checks++; if (c56z !== 6'd55 || e56z !== 1'b0) begin errors++; $display("FAIL tz56_msb cnt=%0d empty=%b want 55/0", c56z, e56z); end
      checks++; if (c56l !== 6'd0  || e56l !== 1'b0) begin errors++; $display("FAIL lz56_msb cnt=%0d empty=%b want 0/0", c56l, e56l); end
      checks++; if (c7l !== 3'd6 || e7l !== 1'b0) begin errors++; $display("FAIL lz7_lsb cnt=%0d empty=%b want 6/0", c7l, e7l); end
      checks++; if (c1l !== 1'b0 || e1l !== 1'b1) begin errors++; $display("FAIL w1_zero cnt=%0d empty=%b want 0/1", c1l, e1l); end
      @(negedge clk);
      in56 = 56'h1;
      step();
      checks++; if (c56l !== 6'd55 || e56l !== 1'b0) begin errors++; $display("FAIL lz56_lsb cnt=%0d empty=%b want 55/0", c56l, e56l); end
   endtask

   task automatic test_midstream_reset();
      @(negedge clk);
      in32 = 32'h0000_0010;
      rst  = 1'b1;
      step();
      step();
      checks++; if (c32z !== 5'd0 || e32z !== 1'b1) begin errors++; $display("FAIL rst_mid cnt=%0d empty=%b want 0/1", c32z, e32z); end
      @(negedge clk);
      rst = 1'b0;
      step();
      checks++; if (c32z !== 5'd4 || e32z !== 1'b0) begin errors++; $display("FAIL rst_release cnt=%0d empty=%b want 4/0", c32z, e32z); end
   endtask

   task automatic test_random();
      logic [4:0] x32z, x32l;
      logic [5:0] x56z, x56l;
      logic [2:0] x7z, x7l;
      bit         z32, z56, z7, z1;
      for (int n = 0; n < 10000; n++) begin
         @(negedge clk);
         case ($urandom_range(0, 3))
            0: begin
               in32 = $urandom;
               in56 = 56'({$urandom, $urandom});
               in7  = 7'($urandom);
               in1  = 1'($urandom);
            end
            1: begin
               in32 = $urandom & $urandom & $urandom & $urandom;
               in56 = 56'({$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom});
               in7  = 7'($urandom & $urandom);
               in1  = 1'($urandom);
            end
            2: begin
               in32 = 32'h1 << $urandom_range(0, 31);
               in56 = 56'h1 << $urandom_range(0, 55);
               in7  = 7'h1 << $urandom_range(0, 6);
               in1  = 1'b1;
            end
            default: begin
               in32 = '0;
               in56 = '0;
               in7  = '0;
               in1  = '0;
            end
         endcase
         x32z = 5'(ref_cnt(64'(in32), 32, 1'b0));
         x32l = 5'(ref_cnt(64'(in32), 32, 1'b1));
         x56z = 6'(ref_cnt(64'(in56), 56, 1'b0));
         x56l = 6'(ref_cnt(64'(in56), 56, 1'b1));
         x7z  = 3'(ref_cnt(64'(in7), 7, 1'b0));
         x7l  = 3'(ref_cnt(64'(in7), 7, 1'b1));
         z32  = (in32 == 0);
         z56  = (in56 == 0);
         z7   = (in7 == 0);
         z1   = (in1 == 0);
         step();
         checks++; if (c32z !== x32z || e32z !== z32) begin errors++; $display("FAIL rnd32z in=%h cnt=%0d/%b want %0d/%b", in32, c32z, e32z, x32z, z32); end
         checks++; if (c32l !== x32l || e32l !== z32) begin errors++; $display("FAIL rnd32l in=%h cnt=%0d/%b want %0d/%b", in32, c32l, e32l, x32l, z32); end
         checks++; if (c56z !== x56z || e56z !== z56) begin errors++; $display("FAIL rnd56z in=%h cnt=%0d/%b want %0d/%b", in56, c56z, e56z, x56z, z56); end
         checks++; if (c56l !== x56l || e56l !== z56) begin errors++; $display("FAIL rnd56l in=%h cnt=%0d/%b want %0d/%b", in56, c56l, e56l, x56l, z56); end
         checks++; if (c7z !== x7z || e7z !== z7) begin errors++; $display("FAIL rnd7z in=%h cnt=%0d/%b want %0d/%b", in7, c7z, e7z, x7z, z7); end
         checks++; if (c7l !== x7l || e7l !== z7) begin errors++; $display("FAIL rnd7l in=%h cnt=%0d/%b want %0d/%b", in7, c7l, e7l, x7l, z7); end
         checks++; if (c1z !== 1'b0 || e1z !== z1) begin errors++; $display("FAIL rnd1z in=%b cnt=%0d/%b want 0/%b", in1, c1z, e1z, z1); end
         checks++; if (c1l !== 1'b0 || e1l !== z1) begin errors++; $display("FAIL rnd1l in=%b cnt=%0d/%b want 0/%b", in1, c1l, e1l, z1); end
         if (errors > 50) break;
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
      $fatal(1);
   end

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_odd_widths();
      test_midstream_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
